// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t : controller state encodings (IDLE=0, REQ=1, DISCARD=2)
//   NOP_WORD      : bubble instruction word; decode uses the same value
//   fetch_entry_t : one buffered {pc, instr} pair
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} pairs with a registered head.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   push        write wdata (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   flush       empty the FIFO; wins over push and pop in the same cycle
//   wdata       entry to write
//   full        DEPTH entries held
//   empty       no entries held
//   head        registered copy of the oldest entry; holds its last value when empty
module instruction_fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CW-1:0] count, count_nx;
    logic          do_push, do_pop;
    fetch_entry_t  head_nx;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The head register is loaded with whatever will be the oldest entry after
    // this edge. When the FIFO is (or is about to be) drained and a push lands,
    // the new word becomes the head directly, since mem[] is not yet written.
    always_comb begin
        rd_ptr_nx = rd_ptr;
        wr_ptr_nx = wr_ptr;
        count_nx  = count;
        head_nx   = head;
        if (flush) begin
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
            count_nx  = '0;
        end else begin
            if (do_pop)  rd_ptr_nx = rd_ptr + PW'(1);
            if (do_push) wr_ptr_nx = wr_ptr + PW'(1);
            count_nx = count + CW'(do_push) - CW'(do_pop);
            if (do_push && ((count - CW'(do_pop)) == '0)) begin
                head_nx = wdata;
            end else if (count_nx != '0) begin
                head_nx = mem[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '{pc: 32'h0, instr: NOP_WORD};
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;
            head   <= head_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: samples the PC, reads instruction memory over req/ack and
// buffers {pc, instr} pairs for decode over valid/ready.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   pc_in          current PC from program_counter
//   redirect       non-sequential PC load at this edge; flushes the buffer
//   pc_advance     one-cycle pulse allowing the PC to step by one
//   imem_req       memory read request
//   imem_addr      word address, stable while imem_req is high
//   imem_ack       read data valid this cycle
//   imem_rdata     instruction word
//   instr_valid    buffer head valid to decode
//   instr          head instruction
//   instr_pc       PC of the head instruction
//   decode_ready   decode accepts the head this cycle
//
// state   | meaning
// IDLE    | waiting for buffer space; samples pc_in when a request can start
// REQ     | read outstanding for req_pc; ack without redirect pushes the word
// DISCARD | read was overtaken by a redirect; wait out the ack and drop data
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int IMEM_AW    = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        pc_in,
    input  logic               redirect,
    output logic               pc_advance,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    input  logic               decode_ready
);

    fetch_state_t state, state_nx;
    logic [31:0]  req_pc;
    logic         sample, push, pop;
    logic         fifo_full, fifo_empty;
    fetch_entry_t wdata, head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_pc    <= '0;
            imem_addr <= '0;
        end else begin
            state <= state_nx;
            if (sample) begin
                req_pc    <= pc_in;
                imem_addr <= pc_in[IMEM_AW-1:0];
            end
        end
    end

    // Space is checked only in IDLE and at most one read is in flight, so a
    // granted request can never push into a full buffer.
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        sample   = 1'b0;
        push     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_full && !redirect) begin
                    sample   = 1'b1;
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    state_nx = imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack) begin
                    push     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign pc_advance = push;
    assign pop        = !fifo_empty && decode_ready;
    assign wdata      = '{pc: req_pc, instr: imem_rdata};

    instruction_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;

    instruction_fetch #(.IMEM_AW(8), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_in        (pc_in),
        .redirect     (redirect),
        .pc_advance   (pc_advance),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .decode_ready (decode_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int adv_cnt = 0;
    int pops  = 0;
    int pop_cycles[$];
    logic [31:0] last_pop_instr = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    // program_counter model: loads the redirect target or steps on pc_advance
    logic [31:0] redirect_target = 32'h0;
    always @(posedge clk) begin
        if (!rst_n)          pc_in <= 32'h0;
        else if (redirect)   pc_in <= redirect_target;
        else if (pc_advance) pc_in <= pc_in + 32'd1;
    end

    // memory model: ack after ack_delay request cycles, data = 0x100 + addr
    int ack_delay = 0;
    int wait_cnt  = 0;
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = 32'h100 + {24'h0, imem_addr};
    always @(posedge clk) begin
        if (!rst_n || !imem_req || imem_ack) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return 32'h100 + {24'h0, pc[7:0]};
    endfunction

    // scoreboard side: every accepted head must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pc_advance) adv_cnt++;
        if (rst_n && instr_valid && decode_ready) begin
            pops++;
            pop_cycles.push_back(cyc);
            last_pop_instr = instr;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc=%h instr=%h expected no pop", instr_pc, instr);
            end else begin
                e = sb.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst_n = 1'b0;
        decode_ready = 1'b0;
        redirect = 1'b1;
        redirect_target = start_pc;
        repeat (2) tick();
        sb.delete();
        pop_cycles.delete();
        pops = 0;
        adv_cnt = 0;
        rst_n = 1'b1;
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pops < n && k < budget) begin tick(); k++; end
        total++;
        if (pops < n) begin
            bad++;
            $display("FAIL %s: got %0d pops expected %0d", name, pops, n);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int k = 0;
        while (!instr_valid && k < budget) begin tick(); k++; end
        check(name, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic wait_req(input int budget, input string name);
        int k = 0;
        while (!imem_req && k < budget) begin tick(); k++; end
        check(name, {31'h0, imem_req}, 32'h1);
    endtask

    typedef struct packed {
        logic [31:0] start_pc;
        int          delay;
        int          n;
        int          gap;
        logic [31:0] exp_last;
    } stream_vec_t;
    stream_vec_t vecs[4];

    initial begin
        int k;
        vecs[0] = '{32'h0000_0000, 0, 3, 2, 32'h102};
        vecs[1] = '{32'h0000_01FE, 0, 4, 2, 32'h101};
        vecs[2] = '{32'hABCD_00F0, 1, 3, 3, 32'h1F2};
        vecs[3] = '{32'h0000_0040, 5, 2, 7, 32'h141};

        // reset, then reset again in the middle of a request
        rst_n = 1'b0;
        redirect = 1'b1;
        redirect_target = 32'h33;
        decode_ready = 1'b0;
        ack_delay = 0;
        repeat (2) tick();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr", {24'h0, imem_addr}, 32'h0);
        rst_n = 1'b1;
        tick();
        redirect = 1'b0;
        wait_valid(20, "t1_fill");
        check("t1_head_instr", instr, 32'h133);
        check("t1_head_pc", instr_pc, 32'h33);
        ack_delay = 10;
        tick();
        check("t1_req", {31'h0, imem_req}, 32'h1);
        check("t1_addr", {24'h0, imem_addr}, 32'h34);
        rst_n = 1'b0;
        tick();
        tick();
        check("t1_rst_req", {31'h0, imem_req}, 32'h0);
        check("t1_rst_valid", {31'h0, instr_valid}, 32'h0);
        check("t1_rst_instr", instr, 32'h0);
        check("t1_rst_instr_pc", instr_pc, 32'h0);
        check("t1_rst_adv", {31'h0, pc_advance}, 32'h0);
        check("t1_rst_addr", {24'h0, imem_addr}, 32'h0);

        // streaming table: start pc, wait states, count, spacing, last word
        for (int v = 0; v < 4; v++) begin
            ack_delay = vecs[v].delay;
            do_reset(vecs[v].start_pc);
            for (int i = 0; i < vecs[v].n; i++)
                sb.push_back('{pc: vecs[v].start_pc + i, instr: exp_word(vecs[v].start_pc + i)});
            decode_ready = 1'b1;
            wait_pops(vecs[v].n, 200, "stream_pops");
            decode_ready = 1'b0;
            for (int i = 1; i < vecs[v].n; i++)
                check("stream_gap", pop_cycles[i] - pop_cycles[i-1], vecs[v].gap);
            check("stream_last", last_pop_instr, vecs[v].exp_last);
            check("stream_sb_left", sb.size(), 0);
        end

        // backpressure: exactly two fetches, then stall; drain in order
        ack_delay = 0;
        do_reset(32'h0);
        repeat (10) tick();
        check("bp_adv", adv_cnt, 2);
        check("bp_req", {31'h0, imem_req}, 32'h0);
        check("bp_valid", {31'h0, instr_valid}, 32'h1);
        check("bp_head_instr", instr, 32'h100);
        check("bp_head_pc", instr_pc, 32'h0);
        repeat (3) tick();
        check("bp_hold_instr", instr, 32'h100);
        check("bp_adv_hold", adv_cnt, 2);
        sb.push_back('{pc: 32'd0, instr: 32'h100});
        sb.push_back('{pc: 32'd1, instr: 32'h101});
        sb.push_back('{pc: 32'd2, instr: 32'h102});
        decode_ready = 1'b1;
        wait_pops(3, 50, "bp_pops");
        decode_ready = 1'b0;
        check("bp_sb_left", sb.size(), 0);

        // redirect during the first request cycle of a slow read
        ack_delay = 3;
        do_reset(32'h10);
        decode_ready = 1'b1;
        sb.push_back('{pc: 32'd40, instr: 32'h128});
        tick();
        check("rd_req", {31'h0, imem_req}, 32'h1);
        check("rd_addr", {24'h0, imem_addr}, 32'h10);
        redirect = 1'b1;
        redirect_target = 32'd40;
        tick();
        redirect = 1'b0;
        k = 0;
        while (imem_req && k < 20) begin k++; tick(); end
        check("rd_discard_cycles", k, 3);
        check("rd_no_adv", adv_cnt, 0);
        wait_req(10, "rd_refetch");
        check("rd_new_addr", {24'h0, imem_addr}, 32'd40);
        wait_pops(1, 50, "rd_pops");
        decode_ready = 1'b0;
        check("rd_adv", adv_cnt, 1);
        check("rd_sb_left", sb.size(), 0);

        // ack + pop + redirect in one cycle with one entry held
        ack_delay = 0;
        do_reset(32'h0);
        wait_valid(20, "co_fill");
        ack_delay = 2;
        sb.push_back('{pc: 32'd0, instr: 32'h100});
        repeat (3) tick();
        check("co_ack", {31'h0, imem_ack}, 32'h1);
        check("co_valid_before", {31'h0, instr_valid}, 32'h1);
        decode_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h80;
        tick();
        decode_ready = 1'b0;
        redirect = 1'b0;
        check("co_valid_after", {31'h0, instr_valid}, 32'h0);
        check("co_adv", adv_cnt, 1);
        check("co_sb_left", sb.size(), 0);
        wait_req(10, "co_refetch");
        check("co_new_addr", {24'h0, imem_addr}, 32'h80);

        // five wait states: address stable, one push, one advance pulse
        ack_delay = 5;
        do_reset(32'h77);
        tick();
        k = 0;
        while (imem_req && k < 20) begin
            check("ws_addr", {24'h0, imem_addr}, 32'h77);
            check("ws_adv_early", adv_cnt, 0);
            k++;
            tick();
        end
        check("ws_req_cycles", k, 6);
        check("ws_adv", adv_cnt, 1);
        check("ws_valid", {31'h0, instr_valid}, 32'h1);
        check("ws_instr", instr, 32'h177);
        check("ws_instr_pc", instr_pc, 32'h77);
        repeat (3) tick();
        check("ws_adv_single", adv_cnt, 1);
        check("ws_instr_hold", instr, 32'h177);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule
